// File: rtl/video_timing_pkg.sv
// Shared timing constants and helpers for the pixel-clock video timing generator.
package video_timing_pkg;

    // Width of the horizontal and vertical position counters.
    localparam int unsigned CNT_W = 12;

    // Default 640x480@60 horizontal timing (pixel clocks).
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;

    // Default 640x480@60 vertical timing (lines).
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // Total period of one axis from its four region lengths.
    function automatic int unsigned calcTotal(input int unsigned active,
                                              input int unsigned fp,
                                              input int unsigned sync,
                                              input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    localparam int unsigned DEF_H_TOTAL = calcTotal(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int unsigned DEF_V_TOTAL = calcTotal(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    // Sync/blank/pulse bundle carried through the delay line.
    typedef struct packed {
        logic hs;
        logic vs;
        logic blk;
        logic frameStart;
        logic lineStart;
        logic frameDrawn;
    } syncBundle_t;

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register with async active-low reset to a given idle vector.
module sync_delay #(
    parameter int unsigned         DEPTH   = 2,
    parameter int unsigned         WIDTH   = 6,
    parameter logic [WIDTH-1:0]    RST_VAL = '0
) (
    input  logic             clkRGB,
    input  logic             nreset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    // Shift din through DEPTH registers; reset loads every stage with the idle vector.
    always_ff @(posedge clkRGB or negedge nreset) begin
        if (!nreset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stages[i] <= RST_VAL;
            end
        end else begin
            stages[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator: free-running h/v counters, raw sync/blank/pulse decode,
// and a PIPE-deep delay line aligning those signals with fetched pixel data.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned PIPE     = 2
) (
    input  logic             clkRGB,
    input  logic             nreset,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hs,
    output logic             vs,
    output logic             blk,
    output logic             frameStart,
    output logic             lineStart,
    output logic             frameDrawn
);

    localparam int unsigned H_TOTAL = calcTotal(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = calcTotal(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam syncBundle_t IDLE = '{
        hs:         ~HS_POL,
        vs:         ~VS_POL,
        blk:        1'b1,
        frameStart: 1'b0,
        lineStart:  1'b0,
        frameDrawn: 1'b0
    };

    syncBundle_t raw;
    syncBundle_t delayed;

    // Horizontal counter wraps every line; vertical advances on that same wrap edge.
    always_ff @(posedge clkRGB or negedge nreset) begin
        if (!nreset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (hcount == H_LAST) begin
            hcount <= '0;
            vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
        end else begin
            hcount <= hcount + 1'b1;
        end
    end

    // Decode sync, blanking and position pulses from the current coordinates.
    always_comb begin
        raw            = IDLE;
        raw.hs         = (hcount >= HS_START && hcount < HS_END) ? HS_POL : ~HS_POL;
        raw.vs         = (vcount >= VS_START && vcount < VS_END) ? VS_POL : ~VS_POL;
        raw.blk        = !(hcount < H_ACT && vcount < V_ACT);
        raw.lineStart  = (hcount == '0);
        raw.frameStart = (hcount == '0) && (vcount == '0);
        raw.frameDrawn = (hcount == '0) && (vcount == V_ACT);
    end

    sync_delay #(
        .DEPTH   (PIPE),
        .WIDTH   ($bits(syncBundle_t)),
        .RST_VAL (IDLE)
    ) uSyncDelay (
        .clkRGB (clkRGB),
        .nreset (nreset),
        .din    (raw),
        .dout   (delayed)
    );

    assign {hs, vs, blk, frameStart, lineStart, frameDrawn} = delayed;

endmodule
